// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encodings, SPI mode
// constants and the bit-counter width.
package spi_pkg;

  // Bit counter width; wide enough to hold DL up to 16 without wrapping.
  localparam int CNT_W = 5;

  // One-hot FSM encodings.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SELECT = 5'b00010,
    ST_SHIFT  = 5'b00100,
    ST_DONE   = 5'b01000,
    ST_WAIT   = 5'b10000
  } state_e;

  // SPI modes as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// sync_edge: STAGES-deep synchronizer with edge pulses. The pulses are decoded
// from the last synchronizer flop and a one-flop history, so they are
// glitch-free and last exactly one clk.
module sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next values of the synchronizer chain and its history flop.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and history registers; reset to the line's idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, DL-bit MSB-first full-duplex frames, CPOL/CPHA
// configurable. All SPI pins are synchronized into clk.
// Optional build macro SPI_SLAVE_OVERRUN_EN adds the sticky rx_overrun output.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   DL          = 8,
  parameter logic CPOL        = 1'b1,
  parameter logic CPHA        = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [DL-1:0] transmit_data,
  output logic          ready,
  output logic [DL-1:0] received_data,
  output logic          rx_valid,
  input  logic          rx_ack
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic          rx_overrun
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DL);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic lead, trail, sample_edge, shift_edge;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [DL-1:0]        tx_shift_q, tx_shift_d;
  logic [DL-1:0]        rx_shift_q, rx_shift_d;
  logic [DL-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 first_q, first_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                 mosi_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // Leading edge moves sclk away from CPOL, trailing edge returns to it.
  assign lead        = (sclk_rise | sclk_fall) & (sclk_s != CPOL);
  assign trail       = (sclk_rise | sclk_fall) & (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign cnt_inc     = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  // mosi needs no edge detection, only the synchronizer chain.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Frame FSM, shift registers, bit counter and receive handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    first_d    = first_q;
    if (rx_ack) rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        tx_shift_d = transmit_data;
        rx_shift_d = '0;
        cnt_d      = '0;
        first_d    = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Abort: the partial frame is dropped, received_data untouched.
          state_d = ST_IDLE;
        end else begin
          if (shift_edge) begin
            // In CPHA=1 the first leading edge only starts the frame.
            if (CPHA && first_q) first_d = 1'b0;
            else tx_shift_d = {tx_shift_q[DL-2:0], 1'b0};
          end
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DL-2:0], mosi_s};
            cnt_d      = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Completion beats a coincident rx_ack.
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      first_q     <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      first_q     <= first_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky flag: a frame landed on an unconsumed word.
  always_comb begin
    overrun_d = overrun_q;
    if ((state_q == ST_DONE) && rx_valid_q && !rx_ack) overrun_d = 1'b1;
    else if (rx_ack && !rx_valid_d)                     overrun_d = 1'b0;
  end

  // Overrun flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign rx_overrun = overrun_q;
`endif

  // In SELECT the word is not yet in tx_shift, so present its MSB directly.
  assign miso_oe       = (state_q != ST_IDLE);
  assign ready         = (state_q == ST_IDLE);
  assign miso          = (state_q == ST_SELECT) ? transmit_data[DL-1]
                                                : (miso_oe & tx_shift_q[DL-1]);
  assign received_data = rx_data_q;
  assign rx_valid      = rx_valid_q;

endmodule
